char_fetch_sequencer: RTL and testbench
=======================================

Name: char_fetch_sequencer

Overview:
Scanline sequencer for the Videotex text path.
- Per active line, fetches one text-RAM word per character cell and presents code, size, part and attribute signals to the character generator with correct timing.
- Strobes the generator's design load and serialises the returned 8-pixel row MSB-first at one pixel per clock.
- Sits between the video timing generator and the pixel/colour mixer.

Parameters:
COLUMNS, 80, character cells per line
CHAR_HEIGHT, 10, scanlines per character row (generator ychar range 0..9)
ROWS, 25, text rows per frame
ADDR_WIDTH, 11, text RAM address width
RAM_LATENCY, 1, clocks from ram_rd to ram_data valid; legal 1..4

Ports:
clk  in  1  pixel clock; also drives generator design load
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-clock pulse; resets row/scanline counters
line_start  in  1  one-clock pulse; starts fetch of current scanline
ram_addr  out  ADDR_WIDTH  text RAM address = row*COLUMNS + column
ram_rd  out  1  one-clock read strobe
ram_data  in  16  [7:0] code, [8] xsize, [9] ysize, [10] underline, [11] invert, [12] ypart, [15:13] colour
gen_index  out  8  character_index to generator
gen_ychar  out  4  effective scanline to generator
gen_xsize, gen_ysize, gen_xpart, gen_ypart, gen_underline, gen_invert  out  1 each  generator controls
gen_load  out  1  generator load enable
row_pixels  in  8  generator output
pixel_out  out  1  serial pixel
pixel_colour  out  3  colour of current cell
pixel_valid  out  1  high during the COLUMNS*8 active pixels
busy  out  1  high outside IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, row=0, ychar=0, column=0, phase=0.
- States:
  - IDLE: on line_start go to PREFETCH, column=0.
  - PREFETCH: runs one 8-clock cell with no pixel_valid, then goes to ACTIVE.
  - ACTIVE: runs COLUMNS cells, then returns to IDLE.
- line_start outside IDLE is ignored.
- Phase counter 0..7 per cell:
  - Phase 0: ram_rd=1, ram_addr = next column; no read after the last column.
  - Phase RAM_LATENCY: ram_data latched.
  - Phase 5 edge: gen_* registered.
  - Phase 6: gen_load=1.
  - Phase 7: row_pixels sampled into the shift register at the 7→0 edge.
  - During phase k of the following cell, pixel_out = bit 7-k.
- Latency: line_start sampled at edge t0; first pixel_valid at t0+9; last at t0+8+COLUMNS*8.
- Double width:
  - If the previous cell had xsize=1 and xpart=0, the current cell reuses the previous code and attributes with xpart=1; its RAM word is ignored.
  - Otherwise xpart=0.
  - A double-width code in the last column is drawn as left half only.
- Double height: gen_ychar = ysize ? (ypart*CHAR_HEIGHT + ychar) >> 1 : ychar, computed at 5 bits and truncated to 4.
- End of ACTIVE:
  - ychar increments; at CHAR_HEIGHT-1 it wraps to 0 and row increments.
  - row wraps ROWS-1 → 0.
- frame_start clears row and ychar at any time. If it arrives mid-line, the current line completes using the old addresses; counters are cleared after it.
- Simultaneous frame_start and line_start in IDLE: counters are cleared first, and the line fetches row 0, ychar 0.
- reset_n low mid-line aborts immediately to IDLE with all outputs 0.

Optional Feature:
CHAR_CURSOR_EN
- Compiled in:
  - Adds inputs cursor_row[4:0], cursor_col[6:0], cursor_on.
  - A 5-bit frame counter increments on frame_start; blink phase = bit 4.
  - When cursor_on, blink phase=1, and the cell matches row/column, gen_invert is XORed with 1.
- Compiled out: ports and counter are absent; gen_invert = ram_data[11].

Test Plan:
- Reset then line_start with RAM word 0x0041 at address 0 -> ram_rd at addr 0 one clock after line_start; pixel_valid rises 9 clocks after line_start; exactly 640 valid clocks; busy falls after.
- Row 0, ychar 9, RAM data underline bit set -> 8 consecutive pixel_out=1 for that cell; neighbouring cell without underline shows its glyph row.
- Column 3 word 0x0141 (xsize), column 4 word 0x0042 -> column 3 gen_xpart=0 and column 4 gen_xpart=1, both with gen_index=0x41; 0x42 never presented.
- Word 0x1241 (ysize, ypart=1) at ychar 4 -> gen_ychar=7; same word with ypart=0 -> gen_ychar=2.
- Issue 10 line_starts -> row increments to 1 and the 11th line reads addresses 80..159; frame_start mid-line -> line completes, next line reads from address 0.
- CHAR_CURSOR_EN with cursor (2,5), 16 frame_starts -> cell (2,5) inverted only when blink bit=1; reset_n low mid-line -> pixel_valid=0 and busy=0 immediately.

Source files
------------

// File: rtl/char_fetch_sequencer.sv
// Scanline text fetch: reads one text-RAM word per cell, drives the character generator and serialises its rows.
// Define CHAR_CURSOR_EN to add the blinking cursor inputs and the frame blink counter.
module char_fetch_sequencer #(
  parameter int COLUMNS     = 80,
  parameter int CHAR_HEIGHT = 10,
  parameter int ROWS        = 25,
  parameter int ADDR_WIDTH  = 11,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_start,
  input  logic                  line_start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd,
  input  logic [15:0]           ram_data,
  output logic [7:0]            gen_index,
  output logic [3:0]            gen_ychar,
  output logic                  gen_xsize,
  output logic                  gen_ysize,
  output logic                  gen_xpart,
  output logic                  gen_ypart,
  output logic                  gen_underline,
  output logic                  gen_invert,
  output logic                  gen_load,
  input  logic [7:0]            row_pixels,
  output logic                  pixel_out,
  output logic [2:0]            pixel_colour,
  output logic                  pixel_valid,
`ifdef CHAR_CURSOR_EN
  input  logic [4:0]            cursor_row,
  input  logic [6:0]            cursor_col,
  input  logic                  cursor_on,
`endif
  output logic                  busy
);

  localparam int CW = $clog2(COLUMNS + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, PREFETCH, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      phase_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q, line_row;
  logic [3:0]      ychar_q, line_ychar;
  logic            fs_pend;
  logic [15:0]     word_q;
  logic            inv_raw;
  logic [2:0]      colour_g, pix_col;
  logic [7:0]      shreg;
  logic            cell_end, fetch_ok, line_done, cursor_hit;
  logic [4:0]      ysum;
  logic [3:0]      ychar_eff;

  // col_q is the column being fetched; the shift register shows the column before it
  assign cell_end  = (phase_q == 3'd7);
  assign fetch_ok  = (state_q != IDLE) && (col_q < CW'(COLUMNS));
  assign line_done = (state_q == ACTIVE) && cell_end && (col_q == CW'(COLUMNS));

  assign ram_rd       = fetch_ok && (phase_q == 3'd0);
  assign ram_addr     = ADDR_WIDTH'(line_row) * ADDR_WIDTH'(COLUMNS) + ADDR_WIDTH'(col_q);
  assign gen_load     = fetch_ok && (phase_q == 3'd6);
  assign pixel_valid  = (state_q == ACTIVE);
  assign pixel_out    = pixel_valid & shreg[7];
  assign pixel_colour = pixel_valid ? pix_col : 3'd0;
  assign busy         = (state_q != IDLE);

  assign ysum      = (word_q[12] ? 5'(CHAR_HEIGHT) : 5'd0) + {1'b0, line_ychar};
  assign ychar_eff = word_q[9] ? 4'(ysum >> 1) : line_ychar;

`ifdef CHAR_CURSOR_EN
  logic [4:0] frame_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 5'd1;
  end

  assign cursor_hit = cursor_on && frame_cnt[4] &&
                      (32'(line_row) == 32'(cursor_row)) && (32'(col_q) == 32'(cursor_col));
`else
  assign cursor_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (line_start) state_d = PREFETCH;
      PREFETCH: if (cell_end)   state_d = ACTIVE;
      ACTIVE:   if (line_done)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      ychar_q    <= '0;
      line_row   <= '0;
      line_ychar <= '0;
      fs_pend    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        phase_q <= '0;
        if (line_start) begin
          col_q      <= '0;
          line_row   <= frame_start ? '0 : row_q;
          line_ychar <= frame_start ? '0 : ychar_q;
        end
      end else begin
        phase_q <= phase_q + 3'd1;
        if (cell_end) col_q <= col_q + CW'(1);
      end

      // the line in flight keeps its latched row/ychar; a frame_start seen meanwhile wins at the end
      if (line_done) begin
        fs_pend <= 1'b0;
        if (frame_start || fs_pend) begin
          row_q   <= '0;
          ychar_q <= '0;
        end else if (line_ychar == 4'(CHAR_HEIGHT - 1)) begin
          ychar_q <= '0;
          row_q   <= (line_row == RW'(ROWS - 1)) ? '0 : line_row + RW'(1);
        end else begin
          ychar_q <= line_ychar + 4'd1;
          row_q   <= line_row;
        end
      end else if (frame_start) begin
        row_q   <= '0;
        ychar_q <= '0;
        if (state_q != IDLE) fs_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q        <= '0;
      gen_index     <= '0;
      gen_ychar     <= '0;
      gen_xsize     <= 1'b0;
      gen_ysize     <= 1'b0;
      gen_xpart     <= 1'b0;
      gen_ypart     <= 1'b0;
      gen_underline <= 1'b0;
      gen_invert    <= 1'b0;
      inv_raw       <= 1'b0;
      colour_g      <= '0;
      pix_col       <= '0;
      shreg         <= '0;
    end else begin
      if (fetch_ok && (phase_q == 3'(RAM_LATENCY))) word_q <= ram_data;

      if (fetch_ok && (phase_q == 3'd5)) begin
        // right half of a double-width glyph: keep the left half's code and attributes
        if ((col_q != '0) && gen_xsize && !gen_xpart) begin
          gen_xpart  <= 1'b1;
          gen_invert <= inv_raw ^ cursor_hit;
        end else begin
          gen_index     <= word_q[7:0];
          gen_xsize     <= word_q[8];
          gen_ysize     <= word_q[9];
          gen_underline <= word_q[10];
          inv_raw       <= word_q[11];
          gen_invert    <= word_q[11] ^ cursor_hit;
          gen_ypart     <= word_q[12];
          colour_g      <= word_q[15:13];
          gen_xpart     <= 1'b0;
          gen_ychar     <= ychar_eff;
        end
      end

      if (cell_end) begin
        if (fetch_ok) begin
          shreg   <= row_pixels;
          pix_col <= colour_g;
        end else begin
          shreg   <= '0;
          pix_col <= '0;
        end
      end else begin
        shreg <= {shreg[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_char_fetch_sequencer.sv
// Directed bench for char_fetch_sequencer: RAM and generator models plus a per-line scoreboard.
module tb_char_fetch_sequencer;

  logic        clk, reset_n, frame_start, line_start;
  logic [10:0] ram_addr;
  logic        ram_rd;
  logic [15:0] ram_data;
  logic [7:0]  gen_index;
  logic [3:0]  gen_ychar;
  logic        gen_xsize, gen_ysize, gen_xpart, gen_ypart, gen_underline, gen_invert, gen_load;
  logic [7:0]  row_pixels;
  logic        pixel_out, pixel_valid, busy;
  logic [2:0]  pixel_colour;
`ifdef CHAR_CURSOR_EN
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        cursor_on;
`endif

  typedef struct packed {logic [7:0] idx; logic [3:0] ych; logic xp; logic inv;} gen_t;
  typedef struct packed {logic [7:0] px; logic [2:0] col;} pix_t;

  logic [15:0] mem [0:2047];
  logic [10:0] addr_q [$];
  gen_t        gen_q [$];
  pix_t        pix_q [$];
  int          checks, failures;
  int          tb_row, tb_ych;
  logic [4:0]  tb_frames;

  char_fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .line_start(line_start),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_data(ram_data),
    .gen_index(gen_index), .gen_ychar(gen_ychar), .gen_xsize(gen_xsize), .gen_ysize(gen_ysize),
    .gen_xpart(gen_xpart), .gen_ypart(gen_ypart), .gen_underline(gen_underline),
    .gen_invert(gen_invert), .gen_load(gen_load), .row_pixels(row_pixels),
    .pixel_out(pixel_out), .pixel_colour(pixel_colour), .pixel_valid(pixel_valid),
`ifdef CHAR_CURSOR_EN
    .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_on(cursor_on),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [7:0] idx, input logic [3:0] y,
                                       input logic ul, input logic inv);
    logic [7:0] g;
    g = idx ^ {y, ~y};
    if (ul && y == 4'd9) g = 8'hFF;
    if (inv) g = ~g;
    return g;
  endfunction

  // one-clock text RAM and a character generator that loads on gen_load
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  always @(posedge clk or negedge reset_n)
    if (!reset_n)      row_pixels <= 8'h00;
    else if (gen_load) row_pixels <= glyph(gen_index, gen_ychar, gen_underline, gen_invert);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_line(input int r, input int y);
    logic [15:0] w;
    logic [7:0]  idx;
    logic [3:0]  ye;
    logic [4:0]  s5;
    logic [2:0]  colr;
    logic        xs, ys, ul, iv, yp, xp, pxs, pxp, hit;
    gen_t g;
    pix_t p;
    pxs = 0; pxp = 0; idx = 0; xs = 0; ys = 0; ul = 0; iv = 0; yp = 0; colr = 0; xp = 0;
    for (int c = 0; c < 80; c++) begin
      w = mem[r*80 + c];
      addr_q.push_back(11'(r*80 + c));
      if (c > 0 && pxs && !pxp) xp = 1;
      else begin
        idx = w[7:0]; xs = w[8]; ys = w[9]; ul = w[10]; iv = w[11]; yp = w[12];
        colr = w[15:13]; xp = 0;
      end
      s5 = (yp ? 5'd10 : 5'd0) + 5'(y);
      ye = ys ? s5[4:1] : 4'(y);
      hit = 0;
`ifdef CHAR_CURSOR_EN
      hit = cursor_on && tb_frames[4] && (r == int'(cursor_row)) && (c == int'(cursor_col));
`endif
      g.idx = idx; g.ych = ye; g.xp = xp; g.inv = iv ^ hit;
      gen_q.push_back(g);
      p.px = glyph(idx, ye, ul, iv ^ hit); p.col = colr;
      pix_q.push_back(p);
      pxs = xs; pxp = xp;
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    tb_row = 0; tb_ych = 0; tb_frames++;
  endtask

  // Runs one scanline from a negedge in IDLE; samples every negedge after the line_start edge.
  task automatic run_line(input bit fs_with, input bit fs_mid, input bit ls_mid, input int rst_at);
    int i, nval, lastv, pc;
    bit done;
    logic [7:0] acc;
    logic [2:0] cobs;
    gen_t g;
    pix_t p;
    if (fs_with) begin tb_row = 0; tb_ych = 0; tb_frames++; end
    push_line(tb_row, tb_ych);
    line_start = 1; frame_start = fs_with;
    @(negedge clk);
    line_start = 0; frame_start = 0;
    i = 0; nval = 0; lastv = -1; pc = 0; done = 0; acc = 0; cobs = 0;
    chk("rd_first_cycle", ram_rd, 1);
    while (!done && i < 800) begin
      if (rst_at != 0 && i == rst_at) begin
        #2 reset_n = 0;
        #1;
        chk("rst_pixel_valid", pixel_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ram_rd", ram_rd, 0);
        chk("rst_gen_load", gen_load, 0);
        chk("rst_gen_index", gen_index, 0);
        addr_q.delete(); gen_q.delete(); pix_q.delete();
        tb_row = 0; tb_ych = 0; tb_frames = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        return;
      end
      if (ram_rd) begin
        chk("rd_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) chk("ram_addr", ram_addr, addr_q.pop_front());
      end
      if (gen_load) begin
        chk("load_expected", gen_q.size() > 0, 1);
        if (gen_q.size() > 0) begin
          g = gen_q.pop_front();
          chk("gen_index", gen_index, g.idx);
          chk("gen_ychar", gen_ychar, g.ych);
          chk("gen_xpart", gen_xpart, g.xp);
          chk("gen_invert", gen_invert, g.inv);
        end
      end
      if (pixel_valid) begin
        if (nval == 0) chk("first_valid_cycle", i, 8);
        nval++; lastv = i;
        if (pc == 0) cobs = pixel_colour;
        acc = {acc[6:0], pixel_out};
        pc++;
        if (pc == 8) begin
          pc = 0;
          chk("cell_expected", pix_q.size() > 0, 1);
          if (pix_q.size() > 0) begin
            p = pix_q.pop_front();
            chk("cell_pixels", acc, p.px);
            chk("cell_colour", cobs, p.col);
          end
        end
      end
      if (!busy) done = 1;
      else begin
        frame_start = (fs_mid && i == 300);
        line_start  = (ls_mid && i == 200);
        i++;
        @(negedge clk);
      end
    end
    frame_start = 0; line_start = 0;
    chk("line_finished", done, 1);
    chk("busy_fall_cycle", i, 648);
    chk("valid_count", nval, 640);
    chk("last_valid_cycle", lastv, 647);
    chk("addr_q_left", addr_q.size(), 0);
    chk("gen_q_left", gen_q.size(), 0);
    chk("pix_q_left", pix_q.size(), 0);
    addr_q.delete(); gen_q.delete(); pix_q.delete();
    if (fs_mid) begin
      tb_row = 0; tb_ych = 0; tb_frames++;
    end else if (tb_ych == 9) begin
      tb_ych = 0;
      tb_row = (tb_row == 24) ? 0 : tb_row + 1;
    end else tb_ych++;
  endtask

  initial begin
    clk = 0; reset_n = 0; line_start = 0; frame_start = 0;
    checks = 0; failures = 0; tb_row = 0; tb_ych = 0; tb_frames = 0;
`ifdef CHAR_CURSOR_EN
    cursor_row = 5'd2; cursor_col = 7'd5; cursor_on = 1;
`endif
    for (int a = 0; a < 2048; a++) mem[a] = {3'(a), 5'b0, 8'(a*37 + 11)};
    mem[0]  = 16'h0041;
    mem[3]  = 16'h0141;  // double width
    mem[4]  = 16'h0042;  // hidden behind the right half
    mem[10] = 16'h1241;  // double height, lower part
    mem[11] = 16'h0241;  // double height, upper part
    mem[20] = 16'h0441;  // underline
    mem[21] = 16'h0041;
    mem[30] = 16'h0841;  // invert
    mem[40] = 16'h1341;
    mem[79] = 16'h0155;  // double width in the last column

    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_pixel_valid", pixel_valid, 0);
    chk("reset_ram_rd", ram_rd, 0);
    chk("reset_ram_addr", ram_addr, 0);
    chk("reset_gen_load", gen_load, 0);
    chk("reset_gen_index", gen_index, 0);
    chk("reset_pixel_out", pixel_out, 0);
    reset_n = 1;
    @(negedge clk);

    run_line(0, 0, 0, 0);                  // row 0, ychar 0
    run_line(0, 0, 1, 0);                  // stray line_start mid-line
    repeat (8) run_line(0, 0, 0, 0);       // ychar 2..9 incl. double height and underline rows
    run_line(0, 0, 0, 0);                  // row 1: addresses 80..159
    run_line(0, 1, 0, 0);                  // frame_start mid-line, still row 1
    run_line(0, 0, 0, 0);                  // back to address 0
    run_line(1, 0, 0, 0);                  // frame_start together with line_start
    run_line(0, 0, 0, 100);                // reset mid-line
    run_line(0, 0, 0, 0);

`ifdef CHAR_CURSOR_EN
    pulse_frame();
    repeat (21) run_line(0, 0, 0, 0);      // reaches row 2 with blink off
    repeat (15) pulse_frame();
    repeat (21) run_line(0, 0, 0, 0);      // row 2 again with blink on
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
